// File: rtl/spi_master_ctrl.sv
// SPI master controller, mode 0 (SCK idles low), one 8-bit transfer per START.
// SCK half-period is CLK_DIV PCLK cycles. A transfer has SETUP, eight SCK
// periods and HOLD. DONE pulses on the same cycle that SS returns high.
// Optional build macro: SPI_MASTER_CTRL_LSB_FIRST_EN selects LSB-first bit
// order for both directions. It is MSB-first when the macro is undefined.
// Timing is the same in both bit orders.

module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic [7:0] TX_DATA,
    input  logic       MISO,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    output logic [7:0] RX_DATA,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] half_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;

    logic       half_done;
    logic       first_bit;
    logic [7:0] tx_load;
    logic       next_bit;
    logic [7:0] tx_next;
    logic [7:0] rx_next;

    assign half_done = (half_cnt == HALF_LAST);

    // The first bit goes straight to MOSI at START, so the TX shift register is
    // loaded already advanced by one position. This keeps "next bit" the
    // same expression for every later falling edge.
`ifdef SPI_MASTER_CTRL_LSB_FIRST_EN
    assign first_bit = TX_DATA[0];
    assign tx_load   = {1'b0, TX_DATA[7:1]};
    assign next_bit  = tx_shift[0];
    assign tx_next   = {1'b0, tx_shift[7:1]};
    assign rx_next   = {MISO, rx_shift[7:1]};
`else
    assign first_bit = TX_DATA[7];
    assign tx_load   = {TX_DATA[6:0], 1'b0};
    assign next_bit  = tx_shift[7];
    assign tx_next   = {tx_shift[6:0], 1'b0};
    assign rx_next   = {rx_shift[6:0], MISO};
`endif

    // Transfer sequencer: state, counters, shift registers and every output are registered here
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            half_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            SCK      <= 1'b0;
            SS       <= 1'b1;
            MOSI     <= 1'b0;
            RX_DATA  <= 8'h00;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if ((state != IDLE) && ABORT) begin
                state    <= IDLE;
                half_cnt <= 8'd0;
                bit_cnt  <= 3'd0;
                SCK      <= 1'b0;
                SS       <= 1'b1;
                BUSY     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START && !ABORT) begin
                            state    <= SETUP;
                            half_cnt <= 8'd0;
                            bit_cnt  <= 3'd0;
                            tx_shift <= tx_load;
                            MOSI     <= first_bit;
                            SS       <= 1'b0;
                            BUSY     <= 1'b1;
                        end
                    end
                    SETUP: begin
                        if (half_done) begin
                            half_cnt <= 8'd0;
                            SCK      <= 1'b1;
                            rx_shift <= rx_next;
                            state    <= SHIFT;
                        end else begin
                            half_cnt <= half_cnt + 8'd1;
                        end
                    end
                    SHIFT: begin
                        if (half_done) begin
                            half_cnt <= 8'd0;
                            if (SCK) begin
                                SCK <= 1'b0;
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= 3'd0;
                                    state   <= HOLD;
                                end else begin
                                    bit_cnt  <= bit_cnt + 3'd1;
                                    MOSI     <= next_bit;
                                    tx_shift <= tx_next;
                                end
                            end else begin
                                SCK      <= 1'b1;
                                rx_shift <= rx_next;
                            end
                        end else begin
                            half_cnt <= half_cnt + 8'd1;
                        end
                    end
                    HOLD: begin
                        if (half_done) begin
                            half_cnt <= 8'd0;
                            SS       <= 1'b1;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                            RX_DATA  <= rx_shift;
                            state    <= IDLE;
                        end else begin
                            half_cnt <= half_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
